// File: rtl/alu_exec_ctrl_pkg.sv
// rtl/alu_exec_ctrl_pkg.sv - opcodes, flag bit positions and FSM encoding for the ALU controller
package alu_exec_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_E = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// rtl/alu_exec_ctrl_if.sv - instruction handshake plus ALU operand/result bus
interface alu_exec_ctrl_if #(
  parameter int DW  = 8,
  parameter int RAW = 2
);
  logic                    instr_valid;
  logic                    instr_ready;
  logic [4+2*RAW+DW-1:0]   instr;
  logic [DW-1:0]           alu_a;
  logic [DW-1:0]           alu_b;
  logic [7:0]              alu_opr;
  logic                    alu_en;
  logic [DW-1:0]           alu_direct;
  logic                    alu_direct_en;
  logic [DW-1:0]           alu_result;

  modport master (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_a, alu_b, alu_opr, alu_en, alu_direct, alu_direct_en
  );

  modport slave (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_a, alu_b, alu_opr, alu_en, alu_direct, alu_direct_en
  );
endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREGS x DW register file, writeback has priority over external load
module alu_regfile #(
  parameter int DW  = 8,
  parameter int RAW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wb_en,
  input  logic [RAW-1:0] wb_sel,
  input  logic [DW-1:0]  wb_data,
  input  logic           ext_en,
  input  logic [RAW-1:0] ext_sel,
  input  logic [DW-1:0]  ext_data,
  input  logic [RAW-1:0] ra_sel,
  output logic [DW-1:0]  ra_data,
  input  logic [RAW-1:0] rb_sel,
  output logic [DW-1:0]  rb_data,
  input  logic [RAW-1:0] dbg_sel,
  output logic [DW-1:0]  dbg_data
);
  localparam int NREGS = 2**RAW;

  logic [DW-1:0]  regs [NREGS];
  logic           wr_en;
  logic [RAW-1:0] wr_sel;
  logic [DW-1:0]  wr_data;

  // A same-edge external load to a different register is dropped; only one write port exists.
  always_comb begin
    wr_en   = wb_en || ext_en;
    wr_sel  = wb_en ? wb_sel  : ext_sel;
    wr_data = wb_en ? wb_data : ext_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_sel] <= wr_data;
    end
  end

  assign ra_data  = regs[ra_sel];
  assign rb_data  = regs[rb_sel];
  assign dbg_data = regs[dbg_sel];
endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - issues one decoded instruction to the ALU every 3 cycles, writes back and keeps flags
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int DW  = 8,
  parameter int RAW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_ctrl_if.slave bus,
  input  logic           reg_wr_en,
  input  logic [RAW-1:0] reg_wr_sel,
  input  logic [DW-1:0]  reg_wr_data,
  input  logic [RAW-1:0] dbg_sel,
  output logic [DW-1:0]  dbg_data,
  output logic [3:0]     flags,
  output logic           done
);
  localparam int IW = 4 + 2*RAW + DW;

  state_t         state, state_nxt;
  logic [IW-1:0]  instr;
  logic           in_imm_sel;
  logic [2:0]     in_op;
  logic [RAW-1:0] in_rd, in_rs;
  logic [DW-1:0]  in_imm;
  logic           accept;

  logic           imm_sel_q;
  logic [2:0]     op_q;
  logic [RAW-1:0] rd_q;
  logic [DW-1:0]  imm_q, a_q, b_q, rs_val_q;
  logic [3:0]     flags_q;

  logic [DW-1:0]  rd_data, rs_data, diff;
  logic           div_zero, wb_en;
  logic           res_z, res_n, res_c;

  assign instr      = bus.instr;
  assign in_imm_sel = instr[IW-1];
  assign in_op      = instr[IW-2 -: 3];
  assign in_rd      = instr[DW+2*RAW-1 -: RAW];
  assign in_rs      = instr[DW+RAW-1 -: RAW];
  assign in_imm     = instr[DW-1:0];
  assign accept     = bus.instr_valid && (state == ST_IDLE);
  assign div_zero   = (op_q == OP_DIV) && (b_q == '0);

  alu_regfile #(.DW(DW), .RAW(RAW)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_en    (wb_en),
    .wb_sel   (rd_q),
    .wb_data  (bus.alu_result),
    .ext_en   (reg_wr_en),
    .ext_sel  (reg_wr_sel),
    .ext_data (reg_wr_data),
    .ra_sel   (in_rd),
    .ra_data  (rd_data),
    .rb_sel   (in_rs),
    .rb_data  (rs_data),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.instr_valid) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready   = 1'b0;
    bus.alu_en        = 1'b0;
    bus.alu_a         = '0;
    bus.alu_b         = '0;
    bus.alu_opr       = '0;
    bus.alu_direct    = '0;
    bus.alu_direct_en = 1'b0;
    done              = 1'b0;
    wb_en             = 1'b0;
    case (state)
      ST_IDLE: bus.instr_ready = 1'b1;
      ST_EXEC, ST_WB: begin
        bus.alu_en        = !div_zero;
        bus.alu_a         = a_q;
        bus.alu_b         = rs_val_q;
        bus.alu_opr       = {5'b0, op_q};
        bus.alu_direct    = imm_q;
        bus.alu_direct_en = imm_sel_q;
        if (state == ST_WB) begin
          done  = 1'b1;
          wb_en = (op_q != OP_CMP) && !div_zero;
        end
      end
      default: ;
    endcase
  end

  // Operands are frozen at accept so later external loads cannot disturb the in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_sel_q <= 1'b0;
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rs_val_q  <= '0;
    end else if (accept) begin
      imm_sel_q <= in_imm_sel;
      op_q      <= in_op;
      rd_q      <= in_rd;
      imm_q     <= in_imm;
      a_q       <= rd_data;
      rs_val_q  <= rs_data;
      b_q       <= in_imm_sel ? in_imm : rs_data;
    end
  end

  always_comb begin
    diff  = a_q - b_q;
    res_z = (bus.alu_result == '0);
    res_n = bus.alu_result[DW-1];
    res_c = 1'b0;
    case (op_q)
      OP_ADD: res_c = ((DW+1)'(a_q) + (DW+1)'(b_q)) > (DW+1)'({DW{1'b1}});
      OP_SUB: res_c = (a_q < b_q);
      OP_MUL: res_c = ((2*DW)'(a_q) * (2*DW)'(b_q)) > (2*DW)'({DW{1'b1}});
      OP_CMP: begin
        res_z = (diff == '0);
        res_n = diff[DW-1];
        res_c = (a_q < b_q);
      end
      default: res_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (state == ST_WB) begin
      if (div_zero) begin
        flags_q[FLAG_E] <= 1'b1;
      end else begin
        flags_q[FLAG_E] <= 1'b0;
        flags_q[FLAG_Z] <= res_z;
        flags_q[FLAG_N] <= res_n;
        flags_q[FLAG_C] <= res_c;
      end
    end
  end

  assign flags = flags_q;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - directed vector table plus multi-cycle sequences for alu_exec_ctrl
module tb_alu_exec_ctrl;
  import alu_exec_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reg_wr_en = 1'b0;
  logic [1:0] reg_wr_sel = '0;
  logic [7:0] reg_wr_data = '0;
  logic [1:0] dbg_sel = '0;
  logic [7:0] dbg_data;
  logic [3:0] flags;
  logic       done;

  alu_exec_ctrl_if #(.DW(8), .RAW(2)) bus ();

  alu_exec_ctrl #(.DW(8), .RAW(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_sel  (reg_wr_sel),
    .reg_wr_data (reg_wr_data),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data),
    .flags       (flags),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit ALU standing in for the real one.
  logic [7:0] alu_bsel;
  always_comb begin
    alu_bsel       = bus.alu_direct_en ? bus.alu_direct : bus.alu_b;
    bus.alu_result = '0;
    if (bus.alu_en) begin
      case (bus.alu_opr[2:0])
        3'd0: bus.alu_result = bus.alu_a + alu_bsel;
        3'd1: bus.alu_result = bus.alu_a - alu_bsel;
        3'd2: bus.alu_result = bus.alu_a * alu_bsel;
        3'd3: bus.alu_result = (alu_bsel != 0) ? bus.alu_a / alu_bsel : 8'h00;
        3'd4: bus.alu_result = bus.alu_a & alu_bsel;
        3'd5: bus.alu_result = bus.alu_a | alu_bsel;
        3'd6: bus.alu_result = bus.alu_a ^ alu_bsel;
        default: bus.alu_result = 8'h00;
      endcase
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [15:0] mk(input logic imm_sel, input logic [2:0] op,
                                     input logic [1:0] rd, input logic [1:0] rs,
                                     input logic [7:0] imm);
    return {imm_sel, op, rd, rs, imm};
  endfunction

  task automatic load(input logic [1:0] r, input logic [7:0] v);
    reg_wr_en = 1'b1; reg_wr_sel = r; reg_wr_data = v;
    @(negedge clk);
    reg_wr_en = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] r, output logic [7:0] v);
    dbg_sel = r;
    #1;
    v = dbg_data;
  endtask

  task automatic issue(input logic [15:0] ins);
    bus.instr = ins; bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 8) begin
      @(negedge clk);
      k++;
    end
    check(name, done, 1'b1);
  endtask

  typedef struct {
    logic       imm_sel;
    logic [2:0] op;
    logic [1:0] rd, rs;
    logic [7:0] imm, a_val, b_val, exp_rd;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [7:0] v;
    logic [8:0] ready_mask;
    bit         done_seen;

    bus.instr_valid = 1'b0;
    bus.instr       = '0;

    // flags column is {E,N,C,Z}
    vecs[0]  = '{1'b0, OP_ADD, 2'd1, 2'd2, 8'h00, 8'd200, 8'd100, 8'd44,  4'b0010};
    vecs[1]  = '{1'b0, OP_SUB, 2'd2, 2'd3, 8'h00, 8'd10,  8'd3,   8'd7,   4'b0000};
    vecs[2]  = '{1'b0, OP_SUB, 2'd0, 2'd1, 8'h00, 8'd3,   8'd10,  8'hF9,  4'b0110};
    vecs[3]  = '{1'b0, OP_MUL, 2'd1, 2'd2, 8'h00, 8'd16,  8'd16,  8'h00,  4'b0011};
    vecs[4]  = '{1'b0, OP_MUL, 2'd1, 2'd2, 8'h00, 8'd7,   8'd9,   8'd63,  4'b0000};
    vecs[5]  = '{1'b0, OP_DIV, 2'd0, 2'd3, 8'h00, 8'd100, 8'd7,   8'd14,  4'b0000};
    vecs[6]  = '{1'b0, OP_AND, 2'd2, 2'd1, 8'h00, 8'hF0,  8'h3C,  8'h30,  4'b0000};
    vecs[7]  = '{1'b0, OP_OR,  2'd3, 2'd0, 8'h00, 8'h80,  8'h01,  8'h81,  4'b0100};
    vecs[8]  = '{1'b0, OP_XOR, 2'd1, 2'd2, 8'h00, 8'h5A,  8'h5A,  8'h00,  4'b0001};
    vecs[9]  = '{1'b1, OP_CMP, 2'd1, 2'd0, 8'd5,  8'd5,   8'h99,  8'd5,   4'b0001};
    vecs[10] = '{1'b0, OP_CMP, 2'd2, 2'd3, 8'h00, 8'd3,   8'd9,   8'd3,   4'b0110};
    vecs[11] = '{1'b1, OP_ADD, 2'd0, 2'd1, 8'h22, 8'h10,  8'h99,  8'h32,  4'b0000};
    vecs[12] = '{1'b0, OP_ADD, 2'd3, 2'd3, 8'h00, 8'h80,  8'h80,  8'h00,  4'b0011};
    vecs[13] = '{1'b0, OP_CMP, 2'd0, 2'd1, 8'h00, 8'h80,  8'h01,  8'h80,  4'b0000};
    vecs[14] = '{1'b0, OP_SUB, 2'd2, 2'd3, 8'h00, 8'hF0,  8'h10,  8'hE0,  4'b0100};
    vecs[15] = '{1'b0, OP_ADD, 2'd1, 2'd0, 8'h00, 8'h70,  8'h20,  8'h90,  4'b0100};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset ready", bus.instr_ready, 1'b1);
    check("reset flags", flags, 4'h0);
    check("reset alu_en", bus.alu_en, 1'b0);
    check("reset done", done, 1'b0);
    for (int r = 0; r < 4; r++) begin
      rd_reg(2'(r), v);
      check($sformatf("reset r%0d", r), v, 8'h00);
    end
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      load(vecs[i].rd, vecs[i].a_val);
      if (vecs[i].rs != vecs[i].rd) load(vecs[i].rs, vecs[i].b_val);
      issue(mk(vecs[i].imm_sel, vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm));
      wait_done($sformatf("vec%0d done", i));
      @(negedge clk);
      rd_reg(vecs[i].rd, v);
      check($sformatf("vec%0d rd", i), v, vecs[i].exp_rd);
      check($sformatf("vec%0d flags", i), flags, vecs[i].exp_flags);
      @(negedge clk);
    end

    // Cycle-accurate CMP with immediate
    load(2'd1, 8'd5);
    check("cmp pre alu_en", bus.alu_en, 1'b0);
    issue(mk(1'b1, OP_CMP, 2'd1, 2'd0, 8'd5));
    check("cmp exec alu_en", bus.alu_en, 1'b1);
    check("cmp exec direct_en", bus.alu_direct_en, 1'b1);
    check("cmp exec direct", bus.alu_direct, 8'd5);
    check("cmp exec opr", bus.alu_opr, 8'd7);
    check("cmp exec a", bus.alu_a, 8'd5);
    check("cmp exec ready", bus.instr_ready, 1'b0);
    check("cmp exec done", done, 1'b0);
    @(negedge clk);
    check("cmp wb alu_en", bus.alu_en, 1'b1);
    check("cmp wb done", done, 1'b1);
    @(negedge clk);
    check("cmp idle done", done, 1'b0);
    check("cmp idle alu_en", bus.alu_en, 1'b0);
    check("cmp idle ready", bus.instr_ready, 1'b1);
    rd_reg(2'd1, v);
    check("cmp r1", v, 8'd5);
    check("cmp flags", flags, 4'b0001);
    @(negedge clk);

    // Divide by zero keeps Z/N/C and rd, sets E; next op clears E
    load(2'd1, 8'd200);
    load(2'd2, 8'd100);
    issue(mk(1'b0, OP_ADD, 2'd1, 2'd2, 8'h00));
    wait_done("dz pre done");
    @(negedge clk);
    check("dz pre flags", flags, 4'b0010);
    load(2'd0, 8'd9);
    load(2'd3, 8'd0);
    issue(mk(1'b0, OP_DIV, 2'd0, 2'd3, 8'h00));
    check("dz exec alu_en", bus.alu_en, 1'b0);
    @(negedge clk);
    check("dz wb alu_en", bus.alu_en, 1'b0);
    check("dz wb done", done, 1'b1);
    @(negedge clk);
    rd_reg(2'd0, v);
    check("dz r0", v, 8'd9);
    check("dz flags", flags, 4'b1010);
    @(negedge clk);
    issue(mk(1'b0, OP_ADD, 2'd0, 2'd3, 8'h00));
    wait_done("dz post done");
    @(negedge clk);
    rd_reg(2'd0, v);
    check("dz post r0", v, 8'd9);
    check("dz post flags", flags, 4'b0000);
    @(negedge clk);

    // Back-to-back: valid held high, accepts every third cycle
    load(2'd0, 8'd0);
    bus.instr = mk(1'b1, OP_ADD, 2'd0, 2'd0, 8'd1);
    bus.instr_valid = 1'b1;
    ready_mask = '0;
    for (int c = 0; c < 9; c++) begin
      ready_mask[c] = bus.instr_ready;
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    check("b2b ready mask", ready_mask, 9'b001001001);
    rd_reg(2'd0, v);
    check("b2b r0", v, 8'd3);
    @(negedge clk);

    // Writeback beats an external load to rd on the same edge
    load(2'd2, 8'd10);
    load(2'd3, 8'd3);
    issue(mk(1'b0, OP_SUB, 2'd2, 2'd3, 8'h00));
    @(negedge clk);
    check("coll wb done", done, 1'b1);
    reg_wr_en = 1'b1; reg_wr_sel = 2'd2; reg_wr_data = 8'h55;
    @(negedge clk);
    reg_wr_en = 1'b0;
    rd_reg(2'd2, v);
    check("coll r2", v, 8'd7);
    @(negedge clk);

    // External write to rs while in flight does not disturb the operands
    load(2'd1, 8'd20);
    load(2'd2, 8'd5);
    issue(mk(1'b0, OP_ADD, 2'd1, 2'd2, 8'h00));
    check("cap alu_b", bus.alu_b, 8'd5);
    reg_wr_en = 1'b1; reg_wr_sel = 2'd2; reg_wr_data = 8'd100;
    @(negedge clk);
    reg_wr_en = 1'b0;
    @(negedge clk);
    rd_reg(2'd1, v);
    check("cap r1", v, 8'd25);
    rd_reg(2'd2, v);
    check("cap r2", v, 8'd100);
    @(negedge clk);

    // Reset in the middle of EXEC aborts without writeback or done
    load(2'd1, 8'd16);
    load(2'd2, 8'd16);
    issue(mk(1'b0, OP_MUL, 2'd1, 2'd2, 8'h00));
    wait_done("rst pre done");
    @(negedge clk);
    check("rst pre flags", flags, 4'b0011);
    load(2'd1, 8'd3);
    issue(mk(1'b1, OP_ADD, 2'd1, 2'd0, 8'd4));
    rst_n = 1'b0;
    #1;
    check("rst alu_en", bus.alu_en, 1'b0);
    check("rst done", done, 1'b0);
    check("rst flags", flags, 4'h0);
    rd_reg(2'd1, v);
    check("rst r1", v, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst ready", bus.instr_ready, 1'b1);
    done_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("rst no done", done_seen, 1'b0);
    rd_reg(2'd1, v);
    check("rst post r1", v, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Upstream control/operand stage that feeds the 8-bit ALU.
- Accepts one decoded ALU instruction per handshake and reads operands from an internal register file.
- Drives the ALU operand, opcode, enable and direct-immediate inputs, then writes the ALU result back to the destination register.
- Maintains the Z/C/N/E flags; computes CMP internally, because the ALU produces no CMP result.

Parameters:
- DW, 8: datapath width; must match the ALU (fixed at 8).
- RAW, 2: register address width; NREGS = 2**RAW.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- instr_valid, input, 1: instruction offered.
- instr_ready, output, 1: block can accept an instruction.
- instr, input, 4+2*RAW+DW: [MSB]=imm_sel, then op[2:0], rd, rs, imm[DW-1:0].
- reg_wr_en, input, 1: external register load, e.g. from memory.
- reg_wr_sel, input, RAW: external load target register.
- reg_wr_data, input, DW: external load data.
- dbg_sel, input, RAW: debug read select.
- dbg_data, output, DW: combinational read of regfile[dbg_sel].
- alu_a, output, DW: ALU A operand.
- alu_b, output, DW: ALU B operand.
- alu_opr, output, 8: ALU opcode, {5'b0, op}.
- alu_en, output, 1: ALU enable.
- alu_direct, output, DW: immediate value to the ALU.
- alu_direct_en, output, 1: selects immediate as B.
- alu_result, input, DW: ALU output bus.
- flags, output, 4: {E,N,C,Z}.
- done, output, 1: one-cycle pulse per retired instruction.

Behaviour:
- Opcodes: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, XOR=6, CMP=7.
- Reset (async, rst_n low):
  - state=IDLE; all registers=0; flags=0.
  - alu_en=0, alu_direct_en=0, alu_a/alu_b/alu_direct/alu_opr=0, done=0.
  - instr_ready=1 once rst_n is released.
- States IDLE, EXEC, WB; instr_ready = (state==IDLE).
- IDLE:
  - On instr_valid && instr_ready, latch instr, A=reg[rd], B = imm_sel ? imm : reg[rs]; go to EXEC.
  - With no valid, remain in IDLE.
- EXEC (one cycle):
  - alu_en=1, alu_opr=op, alu_a=A, alu_b=reg[rs], alu_direct=imm, alu_direct_en=imm_sel.
  - Go to WB.
  - Exception: DIV with B==0 drives alu_en=0 instead.
- WB (one cycle):
  - alu_en stays 1 so the ALU bus remains driven; sample alu_result at the end of WB.
  - If op!=CMP and not div-by-zero, write alu_result into reg[rd].
  - Update flags (rules below); assert done=1; return to IDLE.
- Latency: accept edge T; alu_en high T+1..T+2; writeback and done at T+2; next accept at T+3 earliest (throughput 1 per 3 cycles).
- Flags, computed internally on latched A/B at full width:
  - Z = (result==0); for CMP, Z = (A==B).
  - N = result[DW-1]; for CMP, N = (A-B)[DW-1].
  - C by op:
    - ADD: carry-out of the (DW+1)-bit sum.
    - SUB/CMP: borrow (A<B unsigned).
    - MUL: upper DW bits of the 2*DW product nonzero.
    - AND/OR/XOR/DIV: C=0.
  - E = 1 only for DIV with B==0; otherwise cleared on every retire.
- DIV by zero: rd unchanged; Z/N/C unchanged; E=1; done still pulses.
- Operand capture: operands are taken at the accept edge, so a later external write to rs/rd does not affect the in-flight instruction.
- External write collision: reg_wr_en writes on any edge. If it targets rd on the same edge as writeback, writeback wins.
- rd==rs is legal; the read value is the pre-instruction value.
- Reset mid-operation aborts with no writeback and no done.
- Arithmetic is modulo 2**DW for the register result (ALU truncation).

Decomposition:
- Shared package: opcode localparams ADD..CMP, flag bit indices (Z=0, C=1, N=2, E=3), state encoding.
- One natural sub-module, alu_regfile: NREGS x DW registers, async reset, one write port with priority mux, two combinational read ports plus the debug port.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC -> all registers 0, flags 0, alu_en=0, no done pulse; instr_ready=1 after release.
- Load r1=200, r2=100 via reg_wr; ADD rd=r1, rs=r2 -> r1=44, C=1, Z=0, N=0; done exactly at T+2; alu_en high T+1..T+2.
- CMP r1=5 against imm=5 -> r1 stays 5, Z=1, C=0; alu_direct_en=1 and alu_direct=5 during EXEC.
- DIV r0=9 by r3=0 -> alu_en never asserted, r0=9, E=1; the next ADD clears E.
- Back-to-back: instr_valid held high with 3 instructions -> instr_ready low 2 cycles after each accept; accepts at T, T+3, T+6.
- Collision: reg_wr_en to rd=r2 (value 0x55) on the WB edge of SUB r2=10, rs=3 -> r2=7.
- MUL 16*16 -> result 0, Z=1, C=1.
